// File: rtl/hs32_boot_loader.sv
// hs32_boot_loader: copies a boot image from flash over Wishbone
// into core SRAM, holding the HS32 core in reset until it completes.
module hs32_boot_loader #(
  parameter int AW      = 9,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [31:0]   src_base,
  input  logic [AW:0]   word_count,
  output logic          wbm_cyc_o,
  output logic          wbm_stb_o,
  output logic          wbm_we_o,
  output logic [3:0]    wbm_sel_o,
  output logic [31:0]   wbm_adr_o,
  input  logic [31:0]   wbm_dat_i,
  input  logic          wbm_ack_i,
  input  logic          wbm_err_i,
  output logic          sram_we_o,
  output logic [AW-1:0] sram_addr_o,
  output logic [31:0]   sram_din_o,
  output logic          core_rstn_o,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TONE = TW'(1);
  localparam logic [AW:0]   IONE = (AW + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   base_q, base_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   dat_q, dat_d;
  logic [AW-1:0] sa_q, sa_d;
  logic [AW:0]   idx_nxt;

  assign idx_nxt = idx_q + IONE;

  // State and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      dat_q   <= '0;
      sa_q    <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      dat_q   <= dat_d;
      sa_q    <= sa_d;
    end
  end

  // Next-state: launch, fetch, write back, abort on err/timeout
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    dat_d   = dat_q;
    sa_d    = sa_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          if (word_count == '0) begin
            state_d = S_DONE;
          end else begin
            base_d  = {src_base[31:2], 2'b00};
            cnt_d   = word_count;
            idx_d   = '0;
            tmo_d   = '0;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (wbm_err_i) begin
          state_d = S_ERR;
        end else if (wbm_ack_i) begin
          dat_d   = wbm_dat_i;
          sa_d    = idx_q[AW-1:0];
          state_d = S_WRITE;
        end else if (tmo_q == TMAX) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + TONE;
        end
      end
      S_WRITE: begin
        if (idx_nxt == cnt_q) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_nxt;
          tmo_d   = '0;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign wbm_cyc_o   = (state_q == S_REQ);
  assign wbm_stb_o   = (state_q == S_REQ);
  assign wbm_we_o    = 1'b0;
  assign wbm_sel_o   = 4'hF;
  assign wbm_adr_o   = base_q + {{(29 - AW){1'b0}}, idx_q, 2'b00};
  assign sram_we_o   = (state_q == S_WRITE);
  assign sram_addr_o = sa_q;
  assign sram_din_o  = dat_q;
  assign core_rstn_o = (state_q == S_DONE);
  assign busy        = (state_q == S_REQ) || (state_q == S_WRITE);
  assign done        = (state_q == S_DONE);
  assign error       = (state_q == S_ERR);

endmodule

// File: tb/tb_hs32_boot_loader.sv
// tb_hs32_boot_loader: vector table, hand sequences and random copies
// checked against a word-level copy model and a flash/SRAM model.
module tb_hs32_boot_loader;

  localparam int AW  = 9;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [31:0]   src_base;
  logic [AW:0]   word_count;
  logic          wbm_cyc_o;
  logic          wbm_stb_o;
  logic          wbm_we_o;
  logic [3:0]    wbm_sel_o;
  logic [31:0]   wbm_adr_o;
  logic [31:0]   wbm_dat_i;
  logic          wbm_ack_i;
  logic          wbm_err_i;
  logic          sram_we_o;
  logic [AW-1:0] sram_addr_o;
  logic [31:0]   sram_din_o;
  logic          core_rstn_o;
  logic          busy;
  logic          done;
  logic          error;

  hs32_boot_loader #(.AW(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .src_base(src_base), .word_count(word_count),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_din_o(sram_din_o), .core_rstn_o(core_rstn_o),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // flash image: a few fixed words, a hash everywhere else
  function automatic logic [31:0] fdata(input logic [31:0] a);
    case (a)
      32'h1000_0000: return 32'h0000_CAFE;
      32'h1000_0004: return 32'h0000_0005;
      32'h1000_0008: return 32'h0000_1234;
      32'h1000_000C: return 32'h0000_DEAD;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endcase
  endfunction

  // slave configuration
  logic [31:0] cur_base = '0;
  int          ws       = 0;
  bit          err_en   = 0;
  logic [31:0] err_w    = '0;
  bit          mute_en  = 0;
  logic [31:0] mute_w   = '0;
  int          wcnt     = 0;
  logic [31:0] word_idx;

  assign word_idx  = (wbm_adr_o - cur_base) >> 2;
  assign wbm_ack_i = wbm_stb_o && (wcnt >= ws) &&
                     !(mute_en && word_idx == mute_w);
  assign wbm_err_i = wbm_stb_o && err_en && word_idx == err_w;
  assign wbm_dat_i = fdata(wbm_adr_o);

  // wait-state counter of the slave
  always @(posedge clk)
    wcnt <= (wbm_stb_o && !wbm_ack_i) ? wcnt + 1 : 0;

  // SRAM and activity monitors
  logic [31:0] sram [0:(1<<AW)-1];
  logic [31:0] adr_hist [0:2047];
  int wr_cnt  = 0;
  int cyc_cnt = 0;
  int ack_n   = 0;

  always @(posedge clk) begin
    if (sram_we_o) begin
      sram[sram_addr_o] <= sram_din_o;
      wr_cnt <= wr_cnt + 1;
    end
    if (wbm_cyc_o) cyc_cnt <= cyc_cnt + 1;
    if (wbm_stb_o && wbm_ack_i && !wbm_err_i) begin
      if (ack_n < 2048) adr_hist[ack_n] <= wbm_adr_o;
      ack_n <= ack_n + 1;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // word-level copy model: outcome, cycles from launch edge, writes
  function automatic void model(input int n, input int w,
                                input int errw, input int mutew,
                                output bit d, output int cyc,
                                output int wr);
    int t;
    t = 0; d = 1; wr = 0;
    for (int i = 0; i < n; i++) begin
      if (i == errw) begin t += 1; d = 0; break; end
      if (i == mutew) begin t += TMO; d = 0; break; end
      t += w + 2;
      wr++;
    end
    cyc = t + 1;
  endfunction

  task automatic setup(input logic [31:0] b, input int w,
                       input int errw, input int mutew);
    cur_base = {b[31:2], 2'b00};
    ws       = w;
    err_en   = (errw >= 0);
    err_w    = 32'(errw);
    mute_en  = (mutew >= 0);
    mute_w   = 32'(mutew);
  endtask

  task automatic launch(input logic [31:0] b, input int n);
    @(negedge clk);
    src_base   = b;
    word_count = (AW + 1)'(n);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  // counts launch-edge-relative cycles until done/error
  task automatic wait_end(input string nm, input int c0,
                          output int cyc);
    int bad;
    cyc = c0;
    bad = 0;
    while (!(done || error) && cyc < 400) begin
      if (!busy || core_rstn_o) bad++;
      @(negedge clk);
      cyc++;
    end
    chk({nm, " busy"}, bad, 0);
  endtask

  task automatic verify(input string nm, input int cyc,
                        input int w0, input int c0, input int a0,
                        input bit ed, input int ec, input int ew);
    int bad;
    int nack;
    chk({nm, " outcome"}, {done, error, core_rstn_o},
        ed ? 3'b101 : 3'b010);
    chk({nm, " cycles"}, cyc, ec);
    chk({nm, " writes"}, wr_cnt - w0, ew);
    chk({nm, " buscyc"}, cyc_cnt - c0, ec - 1 - ew);
    bad = 0;
    for (int i = 0; i < ew; i++)
      if (sram[i] !== fdata(cur_base + 32'(4 * i))) bad++;
    chk({nm, " data"}, bad, 0);
    nack = ack_n - a0;
    chk({nm, " acks"}, nack, ew);
    bad = 0;
    for (int j = 0; j < nack && a0 + j < 2048; j++)
      if (adr_hist[a0 + j] !== cur_base + 32'(4 * j)) bad++;
    chk({nm, " addr"}, bad, 0);
  endtask

  task automatic run(input string nm, input logic [31:0] b,
                     input int n, input int w, input int errw,
                     input int mutew, input bit ed, input int ec,
                     input int ew);
    int w0, c0, a0, cyc;
    setup(b, w, errw, mutew);
    w0 = wr_cnt; c0 = cyc_cnt; a0 = ack_n;
    launch(b, n);
    wait_end(nm, 1, cyc);
    verify(nm, cyc, w0, c0, a0, ed, ec, ew);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, " ctrl"},
        {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, sram_we_o,
         core_rstn_o, busy, done, error},
        {3'b000, 4'hF, 5'b00000});
    chk({nm, " buses"}, {wbm_adr_o, sram_addr_o, sram_din_o}, '0);
  endtask

  typedef struct {
    string       nm;
    logic [31:0] base;
    int          n;
    int          w;
    int          errw;
    int          mutew;
    bit          ed;
    int          ec;
    int          ew;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int w0, c0, a0, cyc, found;
    bit md;
    int mc, mw;
    tbl[0] = '{"basic",     32'h1000_0000, 4, 0, -1, -1, 1,  9, 4};
    tbl[1] = '{"zero",      32'h1000_0000, 0, 0, -1, -1, 1,  1, 0};
    tbl[2] = '{"unal_ws3",  32'h2000_0003, 3, 3, -1, -1, 1, 16, 3};
    tbl[3] = '{"bus_err",   32'h1000_0000, 4, 0,  2, -1, 0,  6, 2};
    tbl[4] = '{"timeout",   32'h0000_0100, 2, 0, -1,  0, 0,  9, 0};
    tbl[5] = '{"recover",   32'h0000_0100, 2, 2, -1, -1, 1,  9, 2};
    tbl[6] = '{"tmo_w1",    32'h0800_0000, 3, 0, -1,  1, 0, 11, 1};
    tbl[7] = '{"wrap",      32'hFFFF_FFF8, 4, 1, -1, -1, 1, 13, 4};
    tbl[8] = '{"ws_edge",   32'h0000_4000, 2, 7, -1, -1, 1, 19, 2};
    tbl[9] = '{"single",    32'h0000_0040, 1, 0, -1, -1, 1,  3, 1};

    rstn = 1'b0; start = 1'b0; src_base = '0; word_count = '0;
    repeat (3) @(negedge clk);
    chk_reset("por");
    rstn = 1'b1;
    @(negedge clk);
    chk("idle flags", {busy, done, error, core_rstn_o}, 4'b0000);

    foreach (tbl[i]) begin
      run(tbl[i].nm, tbl[i].base, tbl[i].n, tbl[i].w, tbl[i].errw,
          tbl[i].mutew, tbl[i].ed, tbl[i].ec, tbl[i].ew);
      if (tbl[i].nm == "basic")
        chk("basic image", {sram[0], sram[1], sram[2], sram[3]},
            {32'h0000_CAFE, 32'h5, 32'h1234, 32'h0000_DEAD});
    end

    // second start while busy must be ignored
    setup(32'h4000_0000, 3, -1, -1);
    w0 = wr_cnt; c0 = cyc_cnt; a0 = ack_n;
    launch(32'h4000_0000, 4);
    repeat (3) @(negedge clk);
    src_base = 32'h5000_0000; word_count = 10'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end("busy_start", 5, cyc);
    verify("busy_start", cyc, w0, c0, a0, 1, 21, 4);

    // reset asserted in WRITE of word 1
    setup(32'h3000_0000, 0, -1, -1);
    launch(32'h3000_0000, 4);
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      if (sram_we_o && sram_addr_o == 9'd1) found = 1;
      else @(negedge clk);
    end
    chk("midcopy reached", found, 1);
    rstn = 1'b0;
    #1;
    chk_reset("midcopy rst");
    @(negedge clk);
    rstn = 1'b1;
    run("after_rst", 32'h3000_0000, 4, 0, -1, -1, 1, 9, 4);

    // randomized copies against the word-level model
    for (int r = 0; r < 30; r++) begin
      logic [31:0] b;
      int n, w, mode, ew, mt;
      b    = $urandom;
      n    = $urandom_range(0, 12);
      w    = $urandom_range(0, 4);
      mode = (n == 0) ? 0 : $urandom_range(0, 2);
      ew   = -1;
      mt   = -1;
      if (mode == 1) ew = $urandom_range(0, n - 1);
      if (mode == 2) mt = $urandom_range(0, n - 1);
      model(n, w, ew, mt, md, mc, mw);
      run($sformatf("rnd%0d", r), b, n, w, ew, mt, md, mc, mw);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
